// File: rtl/divider_iter.sv
// divider_iter: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and word forms.
// Define DIVIDER_EARLY_OUT_EN to skip the iterations for divide-by-zero and signed overflow.
module divider_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            sign,
  input  logic            word,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d, rem_q, rem_d, mb_q, mb_d, ax_q, ax_d;
  logic [XLEN-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic            nq_q, nq_d, nr_q, nr_d, word_q, word_d, divz_q, divz_d, ovf_q, ovf_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_x, b_x, ma, mb, min_x, qn, rn, qs, rs, q_fix, r_fix;
  logic [XLEN:0]   trial;
  logic            sa, sb, divz, ovf, ge;
  assign a_x   = word ? {{(XLEN-32){sign & a[31]}}, a[31:0]} : a;
  assign b_x   = word ? {{(XLEN-32){sign & b[31]}}, b[31:0]} : b;
  assign sa    = sign & a_x[XLEN-1];
  assign sb    = sign & b_x[XLEN-1];
  assign ma    = sa ? ~a_x + 1'b1 : a_x;
  assign mb    = sb ? ~b_x + 1'b1 : b_x;
  assign min_x = word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign divz  = b_x == '0;
  assign ovf   = sign && a_x == min_x && b_x == '1;
  // partial remainder is XLEN+1 bits wide; the top bit of trial is the borrow
  assign trial = {rem_q, dvd_q[XLEN-1]} - {1'b0, mb_q};
  assign ge    = ~trial[XLEN];
  assign qn    = nq_q ? ~dvd_q + 1'b1 : dvd_q;
  assign rn    = nr_q ? ~rem_q + 1'b1 : rem_q;
  assign qs    = divz_q ? '1 : ovf_q ? ax_q : qn;
  assign rs    = divz_q ? ax_q : ovf_q ? '0 : rn;
  assign q_fix = word_q ? {{(XLEN-32){qs[31]}}, qs[31:0]} : qs;
  assign r_fix = word_q ? {{(XLEN-32){rs[31]}}, rs[31:0]} : rs;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    mb_d        = mb_q;
    ax_d        = ax_q;
    nq_d        = nq_q;
    nr_d        = nr_q;
    word_d      = word_q;
    divz_d      = divz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: if (start && !flush) begin
`ifdef DIVIDER_EARLY_OUT_EN
        state_d = (divz || ovf) ? S_FIX : S_DIV;
`else
        state_d = S_DIV;
`endif
        cnt_d   = word ? CNT_W'(31) : CNT_W'(XLEN-1);
        dvd_d   = word ? ma << 32 : ma;
        rem_d   = '0;
        mb_d    = mb;
        ax_d    = a_x;
        nq_d    = sa ^ sb;
        nr_d    = sa;
        word_d  = word;
        divz_d  = divz;
        ovf_d   = ovf;
      end
      S_DIV: begin
        rem_d   = ge ? trial[XLEN-1:0] : {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
        dvd_d   = {dvd_q[XLEN-2:0], ge};
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? S_FIX : S_DIV;
      end
      S_FIX: begin
        dvd_d   = q_fix;
        rem_d   = r_fix;
        state_d = S_DONE;
      end
      default: begin
        quotient_d  = dvd_q;
        remainder_d = rem_q;
        valid_d     = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
    if (flush && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      valid_d     = 1'b0;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      mb_q        <= '0;
      ax_q        <= '0;
      nq_q        <= 1'b0;
      nr_q        <= 1'b0;
      word_q      <= 1'b0;
      divz_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      mb_q        <= mb_d;
      ax_q        <= ax_d;
      nq_q        <= nq_d;
      nr_q        <= nr_d;
      word_q      <= word_d;
      divz_q      <= divz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_q     <= valid_d;
    end
  end
  assign busy      = state_q != S_IDLE;
  assign valid     = valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule
